dic_cmd_fsm_p: RTL and testbench
================================

Name: dic_cmd_fsm_p

Overview:
Parametrised successor to the digital-clock control FSM. It decodes per-character detector strobes from the UART character decoder into run/stop control, alarm enable, and sequential multi-digit time/alarm loading. Digit count, per-position digit range, entry timeout and blink rate are all parameters. It sits between the character detector and the digit counter/display datapath.

Parameters:
NUM_DIGITS, 4, number of loadable digits; index NUM_DIGITS-1 is most significant and is loaded first
TENS_MASK, 4'b1010, bit i=1 means position i accepts only 0-5 (det_num0to5); bit i=0 means 0-9 (det_num)
TIMEOUT_CYC, 1000, idle cycles in LOAD before abort; range 1..2^20
BLINK_CYC, 250, half-period of the blink applied to the digit under entry; range >=1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
char_vld  in  1  one-cycle strobe; det_* inputs are sampled only when this is high
det_num  in  1  char is 0-9
det_num0to5  in  1  char is 0-5
det_cr  in  1  carriage return
det_atSign  in  1  '@'
det_A  in  1  A/a
det_L  in  1  L/l
det_S  in  1  S/s
dicRun  out  1  clock counting enabled
alarm_ena  out  1  alarm armed
ld_time  out  1  time-load mode active
ld_alarm  out  1  alarm-load mode active
dicLd  out  NUM_DIGITS  one-hot, one-cycle load strobe for digit i
dicDsp  out  NUM_DIGITS  digit i display enable
ld_done  out  1  one-cycle pulse when the last digit has been loaded
ld_abort  out  1  one-cycle pulse on CR or timeout abort
ld_err  out  1  one-cycle pulse on a rejected character in LOAD

Behaviour:
- Reset (async, rst_n=0): mode=IDLE, run=0, alarm_ena=0, ld_*=0, dicLd=0, pulses=0, pos=NUM_DIGITS-1, timer=0, dicDsp=all ones. Release is synchronous to clk.
- Registered outputs: every response appears the cycle after the char_vld cycle that caused it.
- Character priority when several det_* are set together: cr > num/num0to5 > L > A > S > @.
- IDLE mode, per char_vld:
  - S: run=1.
  - cr: run=0.
  - @: toggle alarm_ena.
  - L: mode=LOAD, ld_time=1, saved_run=run, run forced 0.
  - A: mode=LOAD, ld_alarm=1; run is unchanged.
  - digits are ignored (no ld_err).
- LOAD mode, pos initialised to NUM_DIGITS-1, per char_vld:
  - Valid digit: det_num0to5 if TENS_MASK[pos], else det_num. Pulse dicLd[pos]. If pos==0: pulse ld_done, return to IDLE; otherwise pos-=1.
  - cr: pulse ld_abort, return to IDLE; digits already loaded stay loaded.
  - Any other char, including an out-of-range digit such as '7' at a 0-5 position: pulse ld_err, stay, pos unchanged.
  - S, A, L and @ are not acted on in LOAD; they raise ld_err only.
- Exit from LOAD by any path: ld_time=ld_alarm=0, pos reset. If the exit follows a time load, run restores to saved_run.
- Timeout: timer clears on entry to LOAD and on every char_vld. When the timer reaches TIMEOUT_CYC-1 with no char, pulse ld_abort and exit the same way as CR.
- Blink: in LOAD, dicDsp[pos] toggles every BLINK_CYC cycles, starting ON at entry and at each pos change. All other bits stay 1. In IDLE, all bits are 1.
- char_vld=0: no state change except the timer and blink counters.
- dicRun=run; it is held 0 throughout a time load.
- Reset during LOAD: immediate return to reset values, with no ld_abort pulse.

Test Plan:
1. Reset, then S → dicRun=1 next cycle; then cr → dicRun=0; then @ twice → alarm_ena 1 then 0.
2. Run, L, then '1','2','3','4' → dicRun=0 during the load; dicLd=1000,0100,0010,0001 on successive strobes; ld_done with the last; ld_time falls; dicRun back to 1.
3. A, then '7' at pos 3 (TENS_MASK=1) → ld_err, no dicLd, pos stays 3; then '5' → dicLd[3].
4. L, '2', then cr → ld_abort, mode IDLE, dicLd[3] pulsed only once; run restored.
5. A with TIMEOUT_CYC=20, no chars → ld_abort exactly 20 cycles after entry; ld_alarm=0. Repeat with a char at cycle 15 → abort at cycle 35.
6. L with BLINK_CYC=4 → dicDsp[3] pattern 1111,0000 with period 8 cycles while other bits stay 1; rst_n low mid-load → all outputs at reset values immediately.

Source files
------------

// File: rtl/dic_cmd_fsm_p.sv
// Digital-clock command FSM: decodes character strobes into run/alarm control and MSB-first digit loading.
// All outputs are registered one cycle after char_vld; there is no backpressure, so every strobe is consumed.
module dic_cmd_fsm_p #(
   parameter int                    NUM_DIGITS  = 4,
   parameter logic [NUM_DIGITS-1:0] TENS_MASK   = 4'b1010,
   parameter int                    TIMEOUT_CYC = 1000,
   parameter int                    BLINK_CYC   = 250
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  char_vld,
   input  logic                  det_num,
   input  logic                  det_num0to5,
   input  logic                  det_cr,
   input  logic                  det_atSign,
   input  logic                  det_A,
   input  logic                  det_L,
   input  logic                  det_S,
   output logic                  dicRun,
   output logic                  alarm_ena,
   output logic                  ld_time,
   output logic                  ld_alarm,
   output logic [NUM_DIGITS-1:0] dicLd,
   output logic [NUM_DIGITS-1:0] dicDsp,
   output logic                  ld_done,
   output logic                  ld_abort,
   output logic                  ld_err
);

   localparam int             PW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0]  TOP     = PW'(NUM_DIGITS - 1);
   localparam logic [20:0]    TO_LAST = 21'(TIMEOUT_CYC - 1);
   localparam logic [31:0]    BL_LAST = 32'(BLINK_CYC - 1);

   typedef enum logic {IDLE, LOAD} mode_t;

   mode_t         mode;
   logic          run;
   logic          saved_run;
   logic [PW-1:0] pos;
   logic [20:0]   timer;
   logic [31:0]   bcnt;
   logic          blink_on;

   logic digit_ok;
   assign digit_ok = TENS_MASK[pos] ? det_num0to5 : det_num;
   assign dicRun   = run;

   function automatic logic [NUM_DIGITS-1:0] dsp(input logic [PW-1:0] p, input logic on);
      logic [NUM_DIGITS-1:0] v;
      v    = '1;
      v[p] = on;
      return v;
   endfunction

   // The strobe cycle itself counts as the first idle cycle, so the timer restarts at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode      <= IDLE;
         run       <= 1'b0;
         saved_run <= 1'b0;
         alarm_ena <= 1'b0;
         ld_time   <= 1'b0;
         ld_alarm  <= 1'b0;
         dicLd     <= '0;
         dicDsp    <= '1;
         ld_done   <= 1'b0;
         ld_abort  <= 1'b0;
         ld_err    <= 1'b0;
         pos       <= TOP;
         timer     <= '0;
         bcnt      <= '0;
         blink_on  <= 1'b1;
      end else begin
         dicLd    <= '0;
         ld_done  <= 1'b0;
         ld_abort <= 1'b0;
         ld_err   <= 1'b0;
         case (mode)
            IDLE: begin
               if (char_vld) begin
                  if (det_cr) begin
                     run <= 1'b0;
                  end else if (det_num || det_num0to5) begin
                     run <= run;
                  end else if (det_L || det_A) begin
                     mode     <= LOAD;
                     pos      <= TOP;
                     timer    <= 21'd1;
                     bcnt     <= '0;
                     blink_on <= 1'b1;
                     dicDsp   <= dsp(TOP, 1'b1);
                     if (det_L) begin
                        ld_time   <= 1'b1;
                        saved_run <= run;
                        run       <= 1'b0;
                     end else begin
                        ld_alarm  <= 1'b1;
                     end
                  end else if (det_S) begin
                     run <= 1'b1;
                  end else if (det_atSign) begin
                     alarm_ena <= ~alarm_ena;
                  end
               end
            end
            LOAD: begin
               // Default: advance timer and blink; pos changes and exits override below.
               timer <= timer + 21'd1;
               if (bcnt == BL_LAST) begin
                  bcnt     <= '0;
                  blink_on <= ~blink_on;
                  dicDsp   <= dsp(pos, ~blink_on);
               end else begin
                  bcnt <= bcnt + 32'd1;
               end
               if (char_vld) begin
                  timer <= 21'd1;
                  if (!det_cr && digit_ok) begin
                     dicLd <= NUM_DIGITS'(1) << pos;
                  end
                  if (!det_cr && !digit_ok) begin
                     ld_err <= 1'b1;
                  end else if (!det_cr && pos != '0) begin
                     pos      <= pos - PW'(1);
                     bcnt     <= '0;
                     blink_on <= 1'b1;
                     dicDsp   <= dsp(pos - PW'(1), 1'b1);
                  end
               end
               if ((char_vld && (det_cr || (digit_ok && pos == '0))) ||
                   (!char_vld && timer >= TO_LAST)) begin
                  mode     <= IDLE;
                  ld_time  <= 1'b0;
                  ld_alarm <= 1'b0;
                  pos      <= TOP;
                  timer    <= '0;
                  bcnt     <= '0;
                  blink_on <= 1'b1;
                  dicDsp   <= '1;
                  if (ld_time) run <= saved_run;
                  if (char_vld && !det_cr) ld_done  <= 1'b1;
                  else                     ld_abort <= 1'b1;
               end
            end
            default: mode <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dic_cmd_fsm_p.sv
// Directed bench for dic_cmd_fsm_p with a short timeout and blink period.
module tb_dic_cmd_fsm_p;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       char_vld, det_num, det_num0to5, det_cr, det_atSign, det_A, det_L, det_S;
   logic       dicRun, alarm_ena, ld_time, ld_alarm, ld_done, ld_abort, ld_err;
   logic [3:0] dicLd, dicDsp;

   int vectors     = 0;
   int miscompares = 0;

   dic_cmd_fsm_p #(
      .NUM_DIGITS (4),
      .TENS_MASK  (4'b1010),
      .TIMEOUT_CYC(20),
      .BLINK_CYC  (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .char_vld   (char_vld),
      .det_num    (det_num),
      .det_num0to5(det_num0to5),
      .det_cr     (det_cr),
      .det_atSign (det_atSign),
      .det_A      (det_A),
      .det_L      (det_L),
      .det_S      (det_S),
      .dicRun     (dicRun),
      .alarm_ena  (alarm_ena),
      .ld_time    (ld_time),
      .ld_alarm   (ld_alarm),
      .dicLd      (dicLd),
      .dicDsp     (dicDsp),
      .ld_done    (ld_done),
      .ld_abort   (ld_abort),
      .ld_err     (ld_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      char_vld = 0; det_num = 0; det_num0to5 = 0; det_cr = 0;
      det_atSign = 0; det_A = 0; det_L = 0; det_S = 0;
   endtask

   // Present one character for one cycle; returns 1ns after the sampling edge.
   task automatic send(input byte c);
      char_vld    = 1'b1;
      det_num     = (c >= "0" && c <= "9");
      det_num0to5 = (c >= "0" && c <= "5");
      det_cr      = (c == 8'h0d);
      det_atSign  = (c == "@");
      det_A       = (c == "A");
      det_L       = (c == "L");
      det_S       = (c == "S");
      @(posedge clk); #1;
      clear_in();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_in();
      rst_n = 1'b0;
      idle(2);
      chk("rst_run",   dicRun,    0);
      chk("rst_alarm", alarm_ena, 0);
      chk("rst_ldt",   ld_time,   0);
      chk("rst_lda",   ld_alarm,  0);
      chk("rst_dicld", dicLd,     0);
      chk("rst_dsp",   dicDsp,    4'hF);
      chk("rst_pulse", {ld_done, ld_abort, ld_err}, 0);
      rst_n = 1'b1;
      idle(1);

      // IDLE commands
      send("S");   chk("s_run", dicRun, 1);
      send(8'h0d); chk("cr_run", dicRun, 0);
      send("@");   chk("at1", alarm_ena, 1);
      send("@");   chk("at0", alarm_ena, 0);
      send("3");   chk("idle_dig", {dicLd, ld_err}, 0);

      // Time load 1234 while running
      send("S");
      send("L");   chk("l_ldt", ld_time, 1); chk("l_run", dicRun, 0); chk("l_dsp", dicDsp, 4'hF);
      send("1");   chk("t_ld3", dicLd, 4'b1000); chk("t_run", dicRun, 0);
      send("2");   chk("t_ld2", dicLd, 4'b0100);
      send("3");   chk("t_ld1", dicLd, 4'b0010); chk("t_done0", ld_done, 0);
      send("4");   chk("t_ld0", dicLd, 4'b0001); chk("t_done", ld_done, 1);
      chk("t_ldt_fall", ld_time, 0); chk("t_run_back", dicRun, 1);
      idle(1);     chk("t_pulse_clr", {dicLd, ld_done}, 0);

      // Alarm load with rejected digits
      send("A");   chk("a_lda", ld_alarm, 1); chk("a_run", dicRun, 1);
      send("7");   chk("a_err7", ld_err, 1); chk("a_nold7", dicLd, 0);
      send("5");   chk("a_ld3", dicLd, 4'b1000); chk("a_err_clr", ld_err, 0);
      send("9");   chk("a_ld2", dicLd, 4'b0100);
      send("6");   chk("a_err6", {dicLd, ld_err}, 5'b00001);
      send("0");   chk("a_ld1", dicLd, 4'b0010);
      send("0");   chk("a_ld0", {dicLd, ld_done, ld_alarm}, 6'b000110);
      chk("a_run_end", dicRun, 1);

      // Time load aborted by CR
      send("L");
      send("2");   chk("c_ld3", dicLd, 4'b1000);
      send("S");   chk("c_err_s", {ld_err, dicRun, dicLd}, 6'b100000);
      send(8'h0d); chk("c_abort", {ld_abort, ld_time, dicLd}, 6'b100000);
      chk("c_run", dicRun, 1);
      idle(1);     chk("c_abort_clr", ld_abort, 0);

      // Timeout from entry
      send("A");
      idle(18);    chk("to_pre", {ld_abort, ld_alarm}, 2'b01);
      idle(1);     chk("to_abort", {ld_abort, ld_alarm}, 2'b10);
      idle(1);     chk("to_clr", ld_abort, 0);

      // Timeout restarted by a char at cycle 15
      send("A");
      idle(14);
      send("1");   chk("to2_ld", dicLd, 4'b1000);
      idle(18);    chk("to2_pre", {ld_abort, ld_alarm}, 2'b01);
      idle(1);     chk("to2_abort", {ld_abort, ld_alarm}, 2'b10);

      // Blink of the digit under entry, then reset mid-load
      send("@");   chk("b_alarm", alarm_ena, 1);
      send("L");   chk("b_on1", dicDsp, 4'hF);
      idle(3);     chk("b_on4", dicDsp, 4'hF);
      idle(1);     chk("b_off5", dicDsp, 4'b0111);
      idle(3);     chk("b_off8", dicDsp, 4'b0111);
      idle(1);     chk("b_on9", dicDsp, 4'hF);
      idle(4);     chk("b_off13", dicDsp, 4'b0111);
      rst_n = 1'b0;
      #1;
      chk("r_ldt",   {ld_time, ld_alarm}, 0);
      chk("r_dsp",   dicDsp, 4'hF);
      chk("r_alarm", alarm_ena, 0);
      chk("r_run",   dicRun, 0);
      idle(2);
      chk("r_pulse", {ld_abort, ld_done, ld_err, dicLd}, 0);
      rst_n = 1'b1;
      idle(1);
      send("3");   chk("r_idle", {ld_time, dicLd, ld_err}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
